fetch_sequencer: RTL
====================

# fetch_sequencer

Fetch-stage controller sitting directly upstream of the program counter register and downstream of instruction memory. Each cycle it computes the next PC and its write enable, drives the instruction-memory address, and loads the fetch/decode (F/D) latch. It resolves redirect, stall, freeze and halt priority. A one-entry pending-redirect buffer ensures no branch or jump is lost while the pipeline is frozen.

## Interface
- RESET_PC, 32'd0: PC value loaded on reset and driven as pc_next while in reset.
- NOP, 32'd0: instruction word inserted into the F/D latch on flush or reset.
- ADDR_W, 12: width of the word-addressed instruction-memory address.
- clk  in  1  processor clock. All state updates on the falling edge, the same edge as the program counter register.
- clr_n  in  1  reset. Asynchronous, active-low.
- pc_cur  in  32  current PC, read from the program counter register.
- imem_data  in  32  instruction at imem_addr. Valid before the falling edge of the same cycle.
- stall  in  1  decode hazard stall. Holds PC and F/D; redirect overrides it.
- freeze  in  1  global pipeline freeze (multdiv busy). Holds everything, including redirects.
- redir  in  1  single-cycle pulse from execute: taken branch or jump.
- redir_target  in  32  target PC, valid while redir=1.
- halt  in  1  decode holds a halt instruction.
- pc_next  out  32  data input to the program counter register.
- pc_w_en  out  1  write enable to the program counter register.
- imem_addr  out  ADDR_W  pc_cur[ADDR_W-1:0].
- fd_pc  out  32  PC of the instruction held in the F/D latch.
- fd_insn  out  32  instruction held in the F/D latch.
- fd_valid  out  1  F/D latch holds a live instruction.

## Operation
- State machine, 2-bit encoding:
  - RUN: normal fetch.
  - FROZEN: freeze=1, no pending redirect.
  - PEND: freeze=1 with a buffered redirect.
  - HALTED: fetch stopped.
- Priority per cycle, highest first: clr_n, then freeze, then redir/pending, then halt, then stall, then sequential fetch.
- RUN:
  - redir=1 and freeze=0: pc_next=redir_target, pc_w_en=1, flush F/D (fd_valid=0, fd_insn=NOP, fd_pc=0).
  - halt=1: go to HALTED, pc_w_en=0, flush F/D.
  - stall=1: pc_w_en=0, F/D holds.
  - Otherwise: pc_next=pc_cur+1 (32-bit modulo; 32'hFFFFFFFF wraps to 0), pc_w_en=1, F/D loads {pc_cur, imem_data, 1}.
- Entering a freeze:
  - freeze=1 with redir=0: go to FROZEN, pc_w_en=0, F/D holds.
  - freeze=1 with redir=1: capture redir_target into the pending buffer, go to PEND.
- FROZEN:
  - redir=1 while frozen: capture redir_target, go to PEND.
  - freeze falls: return to RUN and evaluate RUN rules in that cycle.
- PEND:
  - A later redir while still frozen overwrites the buffer (the latest redirect wins).
  - First cycle with freeze=0: pc_next=buffer, pc_w_en=1, flush F/D, clear buffer, go to RUN. The buffer wins over halt and stall in that cycle. A fresh redir in that same cycle takes precedence over the buffer.
- HALTED:
  - pc_w_en=0, fd_valid=0.
  - redir=1 (a branch older than the halt) returns to RUN with pc_next=redir_target and pc_w_en=1.
  - Otherwise HALTED is left only by reset.
- halt together with redir in the same cycle: redir wins and the halt is flushed.
- Reset, asynchronous at any point including mid-PEND:
  - State=RUN, buffer cleared.
  - pc_next=RESET_PC, pc_w_en=0.
  - fd_pc=0, fd_insn=NOP, fd_valid=0.
  - First falling edge after release performs a normal RUN fetch.

## Timing
- pc_next, pc_w_en and imem_addr are combinational from state, inputs and pc_cur. They are settled before the falling edge.
- F/D latch and state register: 1-cycle latency, updated on the falling edge.
- Redirect to new PC in pc_cur: 1 edge. Redirect to first valid target instruction in F/D: 2 edges.
- Redirect buffered during freeze: applied at the first edge after freeze deasserts.
- clr_n assert: outputs reach reset values immediately. Deassert is synchronised externally; this block does not resynchronise it.

## Structure
- Shared processor package holds:
  - state encodings ST_RUN, ST_FROZEN, ST_PEND, ST_HALTED;
  - the NOP constant;
  - RESET_PC default.
- One sub-module: fd_latch. It is a 65-bit falling-edge register with async active-low clear and load/hold/flush control, and is reused by later pipeline latches.
- Next-PC mux, +1 incrementer and state machine are written inline.

## Test plan
- Reset then free-run, imem returns 32'hA000_0000+addr: pc_cur steps 0,1,2,3; fd_insn=32'hA000_0000 one edge after pc_cur=0 with fd_valid=1.
- stall=1 for 2 cycles at pc_cur=5: pc_w_en=0 for those cycles, fd_pc stays 4; fetch resumes at 5→6.
- redir pulse, target 32'h40, at pc_cur=9: next pc_cur=0x40, fd_valid=0 for one cycle, then fd_pc=0x40.
- freeze=1 for 4 cycles with redir pulses to 0x20 then 0x30: PC held; after release pc_cur=0x30, F/D flushed once.
- halt=1 at pc_cur=7: PC frozen at 7 and fd_valid=0 indefinitely. Same test with a simultaneous redir to 0x10: halt ignored, pc_cur=0x10.
- pc_cur=32'hFFFF_FFFF wraps to 0. clr_n pulsed low while in PEND: buffer discarded, pc_next=RESET_PC, fd_valid=0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage types and constants: FSM encodings, F/D latch payload and control.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 12;

  localparam logic [XLEN-1:0] NOP              = 32'd0;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_PEND   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    FD_HOLD  = 2'd0,
    FD_LOAD  = 2'd1,
    FD_FLUSH = 2'd2
  } latch_ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
    logic            valid;
  } fd_entry_t;

  // Bubble written into a pipeline latch on flush or clear.
  function automatic fd_entry_t fd_bubble();
    fd_entry_t b;
    b.pc    = '0;
    b.insn  = NOP;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: PC register, instruction memory, hazard controls and F/D latch view.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic [XLEN-1:0]   pc_cur;
  logic [XLEN-1:0]   imem_data;
  logic              stall;
  logic              freeze;
  logic              redir;
  logic [XLEN-1:0]   redir_target;
  logic              halt;
  logic [XLEN-1:0]   pc_next;
  logic              pc_w_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   fd_pc;
  logic [XLEN-1:0]   fd_insn;
  logic              fd_valid;

  modport slave (
    input  pc_cur, imem_data, stall, freeze, redir, redir_target, halt,
    output pc_next, pc_w_en, imem_addr, fd_pc, fd_insn, fd_valid
  );

  modport master (
    output pc_cur, imem_data, stall, freeze, redir, redir_target, halt,
    input  pc_next, pc_w_en, imem_addr, fd_pc, fd_insn, fd_valid
  );

endinterface

// File: rtl/fetch_sequencer_fd_latch.sv
// Falling-edge pipeline latch with async active-low clear and load/hold/flush control.
module fd_latch
  import fetch_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  latch_ctl_t ctl,
  input  fd_entry_t  d,
  output fd_entry_t  q
);

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= fd_bubble();
    end else begin
      case (ctl)
        FD_LOAD:  q <= d;
        FD_FLUSH: q <= fd_bubble();
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: next-PC selection, F/D latch control and redirect buffering
// across pipeline freezes.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input logic              clk,
  input logic              clr_n,
  fetch_sequencer_if.slave bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] pc_next_c;
  logic            pc_w_en_c;
  latch_ctl_t      fd_ctl;
  fd_entry_t       fd_d, fd_q;

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Priority: reset, freeze, redirect/pending, halt, stall, sequential fetch.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pc_next_c = bus.pc_cur;
    pc_w_en_c = 1'b0;
    fd_ctl    = FD_HOLD;

    if (!clr_n) begin
      pc_next_c = RESET_PC;
      state_d   = ST_RUN;
      pend_d    = '0;
    end else if (bus.freeze) begin
      // Latest redirect seen during a freeze is the one that survives.
      if (bus.redir) begin
        pend_d  = bus.redir_target;
        state_d = ST_PEND;
      end else if (state_q == ST_RUN) begin
        state_d = ST_FROZEN;
      end
    end else if (bus.redir) begin
      pc_next_c = bus.redir_target;
      pc_w_en_c = 1'b1;
      fd_ctl    = FD_FLUSH;
      pend_d    = '0;
      state_d   = ST_RUN;
    end else if (state_q == ST_PEND) begin
      pc_next_c = pend_q;
      pc_w_en_c = 1'b1;
      fd_ctl    = FD_FLUSH;
      pend_d    = '0;
      state_d   = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      fd_ctl = FD_FLUSH;
    end else if (bus.halt) begin
      fd_ctl  = FD_FLUSH;
      state_d = ST_HALTED;
    end else if (bus.stall) begin
      state_d = ST_RUN;
    end else begin
      pc_next_c = XLEN'(bus.pc_cur + 32'd1);
      pc_w_en_c = 1'b1;
      fd_ctl    = FD_LOAD;
      state_d   = ST_RUN;
    end
  end

  always_comb begin
    fd_d.pc    = bus.pc_cur;
    fd_d.insn  = bus.imem_data;
    fd_d.valid = 1'b1;
  end

  fd_latch u_fd_latch (
    .clk   (clk),
    .clr_n (clr_n),
    .ctl   (fd_ctl),
    .d     (fd_d),
    .q     (fd_q)
  );

  assign bus.pc_next   = pc_next_c;
  assign bus.pc_w_en   = pc_w_en_c;
  assign bus.imem_addr = bus.pc_cur[ADDR_W-1:0];
  assign bus.fd_pc     = fd_q.pc;
  assign bus.fd_insn   = fd_q.insn;
  assign bus.fd_valid  = fd_q.valid;

endmodule
